// File: rtl/timebase_pkg.sv
// Shared types for the PWM timebase: operand width, word type and control states.
package timebase_pkg;

  localparam int TB_WIDTH = 30;

  typedef logic [TB_WIDTH-1:0] tb_word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } tb_state_t;

endpackage

// File: rtl/pwm_timebase_comparator.sv
// Unsigned magnitude compare; lt is high when count is strictly below desired.
import timebase_pkg::*;

module comparator #(
  parameter int WIDTH = TB_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] desired,
  output logic             lt
);

  assign lt = (count < desired);

endmodule

// File: rtl/pwm_timebase.sv
// Programmable period/duty timebase feeding the downstream PWM comparator.
// New settings go through a shadow and are applied only at a period boundary.
import timebase_pkg::*;

module pwm_timebase #(
  parameter int WIDTH = TB_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] duty_in,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] desired,
  output logic             wrap,
  output logic             pending,
  output logic             running
);

  tb_state_t        state, state_nxt;
  logic [WIDTH-1:0] period_act, period_nxt;
  logic [WIDTH-1:0] pend_period, pend_period_nxt;
  logic [WIDTH-1:0] pend_duty, pend_duty_nxt;
  logic [WIDTH-1:0] count_nxt, desired_nxt;
  logic             pending_nxt, wrap_nxt;

  // A load in the same cycle as an apply point bypasses the shadow.
  logic [WIDTH-1:0] src_period, src_duty, src_desired;
  logic             src_valid, duty_over;

  assign src_period = load ? period_in : pend_period;
  assign src_duty   = load ? duty_in   : pend_duty;
  assign src_valid  = load | pending;

  comparator #(.WIDTH(WIDTH)) u_clamp (
    .count   (src_period),
    .desired (src_duty),
    .lt      (duty_over)
  );

  assign src_desired = duty_over ? src_period : src_duty;

  always_comb begin
    // NOTE: every target gets its hold value first, so no path through this block can infer a latch.
    state_nxt       = state;
    count_nxt       = count;
    period_nxt      = period_act;
    desired_nxt     = desired;
    pend_period_nxt = pend_period;
    pend_duty_nxt   = pend_duty;
    pending_nxt     = pending;
    wrap_nxt        = 1'b0;

    if (load) begin
      pend_period_nxt = period_in;
      pend_duty_nxt   = duty_in;
      pending_nxt     = 1'b1;
    end

    if (clear) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          count_nxt = '0;
          if (src_valid) begin
            period_nxt  = src_period;
            desired_nxt = src_desired;
            pending_nxt = 1'b0;
          end
          if (enable && (period_nxt != '0)) state_nxt = RUN;
        end

        RUN: begin
          if (!enable) begin
            state_nxt = PAUSE;
          end else if (count == period_act - WIDTH'(1)) begin
            count_nxt = '0;
            wrap_nxt  = 1'b1;
            if (src_valid) begin
              period_nxt  = src_period;
              desired_nxt = src_desired;
              pending_nxt = 1'b0;
              // A zero period cannot run; park in IDLE until a usable one arrives.
              if (src_period == '0) state_nxt = IDLE;
            end
          end else begin
            count_nxt = count + WIDTH'(1);
          end
        end

        PAUSE: begin
          if (enable) state_nxt = RUN;
        end

        default: begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      period_act  <= '0;
      desired     <= '0;
      pend_period <= '0;
      pend_duty   <= '0;
      pending     <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      period_act  <= period_nxt;
      desired     <= desired_nxt;
      pend_period <= pend_period_nxt;
      pend_duty   <= pend_duty_nxt;
      pending     <= pending_nxt;
      wrap        <= wrap_nxt;
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_pwm_timebase.sv
// Table-driven bench for pwm_timebase with a downstream comparator on its outputs.
module tb_pwm_timebase;
  import timebase_pkg::*;

  typedef struct {
    bit rst, en, clr, ld;
    int per, duty;
    int c, d;
    bit w, p, r, lt;
  } vec_t;

  logic     clk = 1'b0;
  logic     reset, enable, clear, load;
  tb_word_t period_in, duty_in, count, desired;
  logic     wrap, pending, running, lt;

  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;
  vec_t sb[$];
  vec_t vecs[$];

  pwm_timebase #(.WIDTH(TB_WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .clear     (clear),
    .load      (load),
    .period_in (period_in),
    .duty_in   (duty_in),
    .count     (count),
    .desired   (desired),
    .wrap      (wrap),
    .pending   (pending),
    .running   (running)
  );

  comparator #(.WIDTH(TB_WIDTH)) u_pwm_cmp (
    .count   (count),
    .desired (desired),
    .lt      (lt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, step_no, act, exp);
    end
  endtask

  function automatic vec_t mkv(bit rst, bit en, bit clr, bit ld, int per, int duty,
                               int c, int d, bit w, bit p, bit r, bit l);
    vec_t v;
    v.rst = rst; v.en = en; v.clr = clr; v.ld = ld; v.per = per; v.duty = duty;
    v.c = c; v.d = d; v.w = w; v.p = p; v.r = r; v.lt = l;
    return v;
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    reset     = v.rst;
    enable    = v.en;
    clear     = v.clr;
    load      = v.ld;
    period_in = tb_word_t'(v.per);
    duty_in   = tb_word_t'(v.duty);
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("count",   32'(count),   32'(e.c));
    check("desired", 32'(desired), 32'(e.d));
    check("wrap",    32'(wrap),    32'(e.w));
    check("pending", 32'(pending), 32'(e.p));
    check("running", 32'(running), 32'(e.r));
    check("pwm_lt",  32'(lt),      32'(e.lt));
    step_no++;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; load = 1'b0;
    period_in = '0; duty_in = '0;

    // Fields: rst en clr ld per duty | count desired wrap pending running lt
    vecs.push_back(mkv(1,0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mkv(0,0,0,1,5,2, 0,2,0,0,0,1));
    vecs.push_back(mkv(0,1,0,0,0,0, 0,2,0,0,1,1));
    vecs.push_back(mkv(0,1,0,0,0,0, 1,2,0,0,1,1));
    vecs.push_back(mkv(0,1,0,0,0,0, 2,2,0,0,1,0));
    vecs.push_back(mkv(0,1,0,0,0,0, 3,2,0,0,1,0));
    vecs.push_back(mkv(0,1,0,0,0,0, 4,2,0,0,1,0));
    vecs.push_back(mkv(0,1,0,0,0,0, 0,2,1,0,1,1));
    vecs.push_back(mkv(0,1,0,0,0,0, 1,2,0,0,1,1));
    vecs.push_back(mkv(0,1,0,0,0,0, 2,2,0,0,1,0));
    vecs.push_back(mkv(0,1,0,0,0,0, 3,2,0,0,1,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mkv(0,0,0,0,0,0, 3,2,0,0,0,0));
    vecs.push_back(mkv(0,1,0,0,0,0, 3,2,0,0,1,0));
    vecs.push_back(mkv(0,1,0,0,0,0, 4,2,0,0,1,0));
    vecs.push_back(mkv(0,1,0,0,0,0, 0,2,1,0,1,1));
    vecs.push_back(mkv(0,1,0,0,0,0, 1,2,0,0,1,1));
    vecs.push_back(mkv(0,1,0,1,3,7, 2,2,0,1,1,0));
    vecs.push_back(mkv(0,1,0,0,0,0, 3,2,0,1,1,0));
    vecs.push_back(mkv(0,1,0,0,0,0, 4,2,0,1,1,0));
    vecs.push_back(mkv(0,1,0,0,0,0, 0,3,1,0,1,1));
    vecs.push_back(mkv(0,1,0,0,0,0, 1,3,0,0,1,1));
    vecs.push_back(mkv(0,1,0,0,0,0, 2,3,0,0,1,1));
    vecs.push_back(mkv(0,1,0,0,0,0, 0,3,1,0,1,1));
    vecs.push_back(mkv(0,1,0,0,0,0, 1,3,0,0,1,1));
    vecs.push_back(mkv(0,1,0,0,0,0, 2,3,0,0,1,1));
    vecs.push_back(mkv(0,1,1,0,0,0, 0,3,0,0,0,1));
    vecs.push_back(mkv(0,1,0,0,0,0, 0,3,0,0,1,1));
    vecs.push_back(mkv(0,1,0,0,0,0, 1,3,0,0,1,1));
    vecs.push_back(mkv(0,1,0,0,0,0, 2,3,0,0,1,1));
    vecs.push_back(mkv(0,1,0,1,1,0, 0,0,1,0,1,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mkv(0,1,0,0,0,0, 0,0,1,0,1,0));
    vecs.push_back(mkv(0,1,0,1,4,1, 0,1,1,0,1,1));
    vecs.push_back(mkv(0,1,0,0,0,0, 1,1,0,0,1,0));
    vecs.push_back(mkv(0,1,0,1,6,3, 2,1,0,1,1,0));
    vecs.push_back(mkv(1,1,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mkv(0,1,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mkv(0,1,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(mkv(0,1,0,1,2,1, 0,1,0,0,1,1));
    vecs.push_back(mkv(0,1,0,1,0,0, 1,1,0,1,1,0));
    vecs.push_back(mkv(0,1,0,0,0,0, 0,0,1,0,0,0));
    vecs.push_back(mkv(0,1,0,0,0,0, 0,0,0,0,0,0));

    foreach (vecs[i]) step(vecs[i]);

    // Load during PAUSE must stay pending until the first rollover after resuming.
    step(mkv(0,1,0,1,3,1, 0,1,0,0,1,1));
    step(mkv(0,0,0,0,0,0, 0,1,0,0,0,1));
    step(mkv(0,0,0,1,2,5, 0,1,0,1,0,1));
    step(mkv(0,0,0,0,0,0, 0,1,0,1,0,1));
    step(mkv(0,1,0,0,0,0, 0,1,0,1,1,1));
    step(mkv(0,1,0,0,0,0, 1,1,0,1,1,0));
    step(mkv(0,1,0,0,0,0, 2,1,0,1,1,0));
    step(mkv(0,1,0,0,0,0, 0,2,1,0,1,1));
    step(mkv(0,1,0,0,0,0, 1,2,0,0,1,1));
    step(mkv(0,1,0,0,0,0, 0,2,1,0,1,1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
